rc_perm_stream_io: RTL and testbench

Streaming front/back end for the dual Reinforced Concrete permutation core. It deserializes a word stream of BN254 field elements into two input states (`inState1`, `inState2`) and launches the core with `enable`. It waits for `done`, captures both output states, and serializes them onto an output word stream. It sits between the host/AXI-stream fabric and the two-instance permutation wrapper.

---
 rtl/rc_perm_stream_io.sv | 150 +++++++++++++++
 tb/tb_rc_perm_stream_io.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc_perm_stream_io.sv
// Word-stream front/back end for the dual Reinforced Concrete permutation core:
// deserialises two input states, launches the core, and serialises both results.
module rc_perm_stream_io #(
  parameter int STATE_SIZE = 3,
  parameter int LANES      = 13,
  parameter int N_BITS     = 254,
  localparam int WORDS     = 2 * STATE_SIZE * LANES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BITS-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [N_BITS-1:0] perm_inState1  [STATE_SIZE][LANES],
  output logic [N_BITS-1:0] perm_inState2  [STATE_SIZE][LANES],
  output logic              perm_enable,
  input  logic [N_BITS-1:0] perm_outState1 [STATE_SIZE][LANES],
  input  logic [N_BITS-1:0] perm_outState2 [STATE_SIZE][LANES],
  input  logic              perm_done,
  output logic [N_BITS-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy
);

  localparam int                HALF  = STATE_SIZE * LANES;
  localparam int                CNT_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              s_ready_q;
  logic              enable_q;
  logic              m_valid_q;
  logic              busy_q;

  // Flat word-ordered storage: state1 words at [0..HALF-1], state2 after.
  logic [N_BITS-1:0] in_q  [WORDS];
  logic [N_BITS-1:0] out_q [WORDS];

  logic accept;
  logic capture;
  logic handshake;

  assign accept    = (state_q == ST_LOAD) && s_ready_q && s_valid;
  assign capture   = (state_q == ST_WAIT) && perm_done;
  assign handshake = (state_q == ST_DRAIN) && m_valid_q && m_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_LOAD;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      enable_q  <= 1'b0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            if (cnt_q == LAST) begin
              state_q   <= ST_START;
              cnt_q     <= '0;
              s_ready_q <= 1'b0;
              enable_q  <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_START: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (perm_done) begin
            state_q   <= ST_DRAIN;
            cnt_q     <= '0;
            enable_q  <= 1'b0;
            m_valid_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (handshake) begin
            if (cnt_q == LAST) begin
              state_q   <= ST_LOAD;
              cnt_q     <= '0;
              m_valid_q <= 1'b0;
              s_ready_q <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_LOAD;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < WORDS; k++) begin
        in_q[k]  <= '0;
        out_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        in_q[cnt_q] <= s_data;
      end
      if (capture) begin
        for (int unsigned i = 0; i < STATE_SIZE; i++) begin
          for (int unsigned j = 0; j < LANES; j++) begin
            out_q[i*LANES + j]        <= perm_outState1[i][j];
            out_q[HALF + i*LANES + j] <= perm_outState2[i][j];
          end
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < STATE_SIZE; i++) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        perm_inState1[i][j] = in_q[i*LANES + j];
        perm_inState2[i][j] = in_q[HALF + i*LANES + j];
      end
    end
  end

  assign s_ready     = s_ready_q;
  assign perm_enable = enable_q;
  assign m_valid     = m_valid_q;
  assign busy        = busy_q;
  assign m_data      = out_q[cnt_q];
  assign m_last      = m_valid_q && (cnt_q == LAST);

endmodule

// File: tb/tb_rc_perm_stream_io.sv
// Scoreboard bench for rc_perm_stream_io with a core stub (done 5 cycles after
// enable, outState = inState ^ 1).
module tb_rc_perm_stream_io;

  localparam int S  = 3;
  localparam int L  = 13;
  localparam int NB = 254;
  localparam int W  = 2 * S * L;

  typedef struct {
    logic [NB-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [NB-1:0] in1  [S][L];
  logic [NB-1:0] in2  [S][L];
  logic [NB-1:0] out1 [S][L];
  logic [NB-1:0] out2 [S][L];
  logic          perm_enable;
  logic          perm_done;
  logic [NB-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   hs_total = 0;
  int   n_hold = 0;
  int   bp_base = 0;
  bit   bp_mode = 1'b0;
  bit   force_done = 1'b0;
  int   ecnt;

  always #5 clk = ~clk;

  rc_perm_stream_io #(.STATE_SIZE(S), .LANES(L), .N_BITS(NB)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .perm_inState1(in1), .perm_inState2(in2), .perm_enable(perm_enable),
    .perm_outState1(out1), .perm_outState2(out2), .perm_done(perm_done),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy)
  );

  // Core stub: done clears whenever enable is low.
  always @(posedge clk or negedge reset) begin
    if (!reset)            ecnt <= 0;
    else if (!perm_enable) ecnt <= 0;
    else if (ecnt < 7)     ecnt <= ecnt + 1;
  end
  assign perm_done = force_done | (ecnt >= 5);

  always_comb begin
    for (int i = 0; i < S; i++) begin
      for (int j = 0; j < L; j++) begin
        out1[i][j] = in1[i][j] ^ NB'(1);
        out2[i][j] = in2[i][j] ^ NB'(1);
      end
    end
  end

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream driver: stall 3 cycles when word 10 of the backpressure batch is presented.
  initial begin
    int stall = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (!bp_mode) stall = 0;
      if (bp_mode && m_valid && (hs_total - bp_base) == 10 && stall < 3) begin
        m_ready = 1'b0;
        stall++;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks hold under stall.
  initial begin
    bit            prev_stall = 1'b0;
    logic [NB-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        sb.delete();
        prev_stall = 1'b0;
      end else begin
        if (s_ready) chk("enable_in_load", NB'(perm_enable), NB'(0));
        if (prev_stall && m_valid) begin
          chk("hold_data", m_data, prev_data);
          chk("hold_last", NB'(m_last), NB'(prev_last));
          n_hold++;
        end
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", NB'(sb.size()), NB'(1));
          end else begin
            e = sb.pop_front();
            chk("m_data", m_data, e.data);
            chk("m_last", NB'(m_last), NB'(e.last));
          end
          hs_total++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  task automatic send_batch(input logic [NB-1:0] base, input bit gap);
    for (int k = 0; k < W; k++) begin
      int t = 0;
      s_data  = base + NB'(k);
      s_valid = 1'b1;
      @(negedge clk);
      while (!s_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!s_ready) chk("load_timeout", NB'(s_ready), NB'(1));
      @(posedge clk);
      #1;
      sb.push_back('{data: (base + NB'(k)) ^ NB'(1), last: (k == W - 1)});
      if (gap && k != W - 1) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b0;
    chk("start_enable", NB'(perm_enable), NB'(1));
    chk("start_s_ready", NB'(s_ready), NB'(0));
  endtask

  task automatic wait_drain(input int base_hs);
    int t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while ((hs_total - base_hs) < W && t < 2000);
    chk("drain_count", NB'(hs_total - base_hs), NB'(W));
    chk("busy_before_last", NB'(busy), NB'(1));
    @(posedge clk);
    #1;
    chk("busy_between", NB'(busy), NB'(0));
    chk("s_ready_after_last", NB'(s_ready), NB'(1));
    chk("m_valid_after_last", NB'(m_valid), NB'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, NB'(s_ready), NB'(0));
    chk({tag, "_m_valid"}, NB'(m_valid), NB'(0));
    chk({tag, "_m_last"}, NB'(m_last), NB'(0));
    chk({tag, "_enable"}, NB'(perm_enable), NB'(0));
    chk({tag, "_busy"}, NB'(busy), NB'(0));
    chk({tag, "_m_data"}, m_data, NB'(0));
    chk({tag, "_in1_00"}, in1[0][0], NB'(0));
    chk({tag, "_in2_2_12"}, in2[2][12], NB'(0));
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk({tag, "_s_ready_pre"}, NB'(s_ready), NB'(0));
    @(posedge clk);
    #1;
    chk({tag, "_s_ready_post"}, NB'(s_ready), NB'(1));
  endtask

  initial begin
    int b;
    int t;
    reset   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("por_s_ready_pre", NB'(s_ready), NB'(0));
    @(posedge clk);
    #1;
    chk("por_s_ready_post", NB'(s_ready), NB'(1));

    // Back-to-back load, words k+1
    b = hs_total;
    send_batch(NB'(1), 1'b0);
    chk("b1_in1_00", in1[0][0], NB'(1));
    chk("b1_in2_2_12", in2[2][12], NB'(78));
    wait_drain(b);

    // Gapped load with spurious done in LOAD and START, plus backpressure
    force_done = 1'b1;
    bp_base    = hs_total;
    bp_mode    = 1'b1;
    b          = hs_total;
    n_hold     = 0;
    send_batch(NB'(1), 1'b1);
    chk("b2_in1_00", in1[0][0], NB'(1));
    chk("b2_in2_2_12", in2[2][12], NB'(78));
    @(posedge clk);
    #1;
    force_done = 1'b0;
    chk("no_capture_in_start", NB'(m_valid), NB'(0));
    chk("wait_enable", NB'(perm_enable), NB'(1));
    wait_drain(b);
    bp_mode = 1'b0;
    chk("hold_cycles", NB'(n_hold), NB'(3));

    // Reset in WAIT
    send_batch(NB'(200), 1'b0);
    @(posedge clk);
    #1;
    reset_pulse("rst_wait");

    // Reset in DRAIN around word 40
    send_batch(NB'(300), 1'b0);
    b = hs_total;
    t = 0;
    while ((hs_total - b) < 40 && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("drain40_reached", NB'(hs_total - b), NB'(40));
    reset_pulse("rst_drain");

    // Fresh batch after resets
    b = hs_total;
    send_batch(NB'(500), 1'b0);
    wait_drain(b);

    // Two consecutive batches, k then 1000+k
    b = hs_total;
    send_batch(NB'(0), 1'b0);
    wait_drain(b);
    b = hs_total;
    send_batch(NB'(1000), 1'b0);
    chk("b6_in1_00", in1[0][0], NB'(1000));
    chk("b6_in2_2_12", in2[2][12], NB'(1077));
    wait_drain(b);

    chk("sb_empty", NB'(sb.size()), NB'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
